enemy_scheduler: RTL and testbench

Owns up to NUM_ENEMIES enemy slots that share one 32x32 enemy bitmap. It spawns enemies on a frame timer, moves them once per frame, and retires them on a hit or when they leave the screen. Per pixel, it picks the owning slot and drives offsetX, offsetY and InsideRectangle to the bitmap. It also returns a slot tag aligned with the bitmap's drawingRequest so the collision logic can report hits per slot.

---
 rtl/enemy_scheduler_if.sv | 27 ++
 rtl/enemy_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_enemy_scheduler.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/enemy_scheduler_if.sv
// Pixel-side bus of enemy_scheduler: scan position and frame/level/hit strobes in,
// bitmap addressing, slot tag and slot status out.
interface enemy_scheduler_if #(
    parameter int NUM_ENEMIES = 4
);
    logic [10:0]            pixelX;
    logic [10:0]            pixelY;
    logic                   startOfFrame;
    logic                   lvl_index;
    logic                   hit;
    logic [10:0]            offsetX;
    logic [10:0]            offsetY;
    logic                   InsideRectangle;
    logic [2:0]             draw_slot;
    logic [NUM_ENEMIES-1:0] active_mask;
    logic [3:0]             enemy_count;

    modport master (
        output pixelX, pixelY, startOfFrame, lvl_index, hit,
        input  offsetX, offsetY, InsideRectangle, draw_slot, active_mask, enemy_count
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, lvl_index, hit,
        output offsetX, offsetY, InsideRectangle, draw_slot, active_mask, enemy_count
    );
endinterface

// File: rtl/enemy_scheduler.sv
// Enemy slot scheduler: spawns, moves and retires NUM_ENEMIES slots sharing one 32x32 bitmap.
// Optional macro ENEMY_BLINK_EN makes DYING slots blink (visible while dying counter bit 1 is set).
module enemy_slot #(
    parameter logic [10:0] LANE_Y       = 11'd64,
    parameter bit          LEFT_MOVER   = 1'b0,
    parameter int          SPEED        = 1,
    parameter int          LEFT_BOUND   = 0,
    parameter int          RIGHT_BOUND  = 608,
    parameter int          DYING_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sof,
    input  logic        spawn,
    input  logic        hit,
    input  logic [10:0] px,
    input  logic [10:0] py,
    output logic        busy,
    output logic        cand,
    output logic [10:0] ox,
    output logic [10:0] oy
);
    localparam int DW = ($clog2(DYING_FRAMES + 1) < 2) ? 2 : $clog2(DYING_FRAMES + 1);
    localparam logic [11:0] LB12 = 12'(LEFT_BOUND);
    localparam logic [11:0] RB12 = 12'(RIGHT_BOUND);
    localparam logic [11:0] SP12 = 12'(SPEED);

    typedef enum logic [1:0] {IDLE, ACTIVE, DYING} state_t;

    state_t          state;
    logic [10:0]     x;
    logic [DW-1:0]   dcnt;
    logic [11:0]     x_ext, x_inc, px_ext, py_ext, y_ext;
    logic [10:0]     x_dec;
    logic            visible, in_x, in_y;

    assign x_ext  = {1'b0, x};
    assign x_inc  = x_ext + SP12;
    assign x_dec  = x - SP12[10:0];
    assign px_ext = {1'b0, px};
    assign py_ext = {1'b0, py};
    assign y_ext  = {1'b0, LANE_Y};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            dcnt  <= '0;
        end else begin
            case (state)
                IDLE: if (spawn) begin
                    state <= ACTIVE;
                    x     <= LEFT_MOVER ? RB12[10:0] : LB12[10:0];
                end
                // A hit on the same cycle as startOfFrame freezes the slot where it was hit.
                ACTIVE: if (hit) begin
                    state <= DYING;
                    dcnt  <= DW'(DYING_FRAMES);
                end else if (sof) begin
                    if (LEFT_MOVER) begin
                        if (x_ext < LB12 + SP12) state <= IDLE;
                        else                     x     <= x_dec;
                    end else begin
                        if (x_inc > RB12) state <= IDLE;
                        else              x     <= x_inc[10:0];
                    end
                end
                DYING: if (sof) begin
                    if (dcnt <= DW'(1)) state <= IDLE;
                    else                dcnt  <= dcnt - DW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ENEMY_BLINK_EN
    assign visible = (state == ACTIVE) || ((state == DYING) && dcnt[1]);
`else
    assign visible = (state == ACTIVE);
`endif

    assign in_x = (px_ext >= x_ext) && (px_ext < x_ext + 12'd32);
    assign in_y = (py_ext >= y_ext) && (py_ext < y_ext + 12'd32);
    assign cand = visible && in_x && in_y;
    assign busy = (state != IDLE);
    assign ox   = px - x;
    assign oy   = py - LANE_Y;
endmodule

module enemy_scheduler #(
    parameter int NUM_ENEMIES  = 4,
    parameter int SPAWN_PERIOD = 120,
    parameter int SPEED        = 1,
    parameter int LEFT_BOUND   = 0,
    parameter int RIGHT_BOUND  = 608,
    parameter int LANE_Y0      = 64,
    parameter int LANE_PITCH   = 96,
    parameter int DYING_FRAMES = 16
) (
    input logic               clk,
    input logic               resetN,
    enemy_scheduler_if.slave  bus
);
    localparam int CW = $clog2(SPAWN_PERIOD + 1);
    localparam logic [CW-1:0] LAST = CW'(SPAWN_PERIOD - 1);

    logic [CW-1:0]                fcnt;
    logic [NUM_ENEMIES-1:0]       busy, cand, spawn_vec, hit_vec;
    logic [NUM_ENEMIES-1:0][10:0] ox, oy;
    logic                         spawn_due, any_idle, win_hit;
    logic [2:0]                   win_idx;
    logic [10:0]                  win_ox, win_oy;
    logic [3:0]                   busy_cnt;

    logic                         inside_q;
    logic [10:0]                  offx_q, offy_q;
    logic [2:0]                   tag_q, draw_q;
    logic [NUM_ENEMIES-1:0]       mask_q;
    logic [3:0]                   count_q;

    for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_slot
        assign hit_vec[i] = bus.hit && (bus.draw_slot == 3'(i));
        enemy_slot #(
            .LANE_Y      (11'(LANE_Y0 + i * LANE_PITCH)),
            .LEFT_MOVER  ((i % 2) == 1),
            .SPEED       (SPEED),
            .LEFT_BOUND  (LEFT_BOUND),
            .RIGHT_BOUND (RIGHT_BOUND),
            .DYING_FRAMES(DYING_FRAMES)
        ) u_slot (
            .clk  (clk),
            .rst  (resetN),
            .sof  (bus.startOfFrame),
            .spawn(spawn_vec[i]),
            .hit  (hit_vec[i]),
            .px   (bus.pixelX),
            .py   (bus.pixelY),
            .busy (busy[i]),
            .cand (cand[i]),
            .ox   (ox[i]),
            .oy   (oy[i])
        );
    end

    // Eligibility uses pre-edge slot states, so a slot freed this frame cannot respawn this frame.
    always_comb begin
        spawn_due = bus.startOfFrame && bus.lvl_index && (fcnt == LAST);
        spawn_vec = '0;
        any_idle  = 1'b0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                spawn_vec    = '0;
                spawn_vec[i] = spawn_due;
                any_idle     = 1'b1;
            end
        end
    end

    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        win_ox  = '0;
        win_oy  = '0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_hit = 1'b1;
                win_idx = 3'(i);
                win_ox  = ox[i];
                win_oy  = oy[i];
            end
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) busy_cnt = busy_cnt + 4'(busy[i]);
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            fcnt     <= '0;
            inside_q <= 1'b0;
            offx_q   <= '0;
            offy_q   <= '0;
            tag_q    <= '0;
            draw_q   <= '0;
            mask_q   <= '0;
            count_q  <= '0;
        end else begin
            // With every slot busy the counter parks at LAST and retries each frame.
            if (!bus.lvl_index) fcnt <= '0;
            else if (bus.startOfFrame) begin
                if (fcnt != LAST)  fcnt <= fcnt + CW'(1);
                else if (any_idle) fcnt <= '0;
            end
            inside_q <= win_hit;
            offx_q   <= win_ox;
            offy_q   <= win_oy;
            tag_q    <= win_idx;
            draw_q   <= tag_q;
            mask_q   <= busy;
            count_q  <= busy_cnt;
        end
    end

    assign bus.InsideRectangle = inside_q;
    assign bus.offsetX         = offx_q;
    assign bus.offsetY         = offy_q;
    assign bus.draw_slot       = draw_q;
    assign bus.active_mask     = mask_q;
    assign bus.enemy_count     = count_q;
endmodule

// File: tb/tb_enemy_scheduler.sv
// Self-checking bench for enemy_scheduler: pixel probe table with a scoreboard queue,
// plus hand-written spawn/hit/exit/reset sequences. Lanes are 16 px apart so slots can overlap.
module tb_enemy_scheduler;
`ifdef ENEMY_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    enemy_scheduler_if #(.NUM_ENEMIES(4)) bus();
    enemy_scheduler #(.NUM_ENEMIES(4), .LANE_PITCH(16)) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int    due;
        bit    is_slot;
        int    ins, ox, oy, slot;
        string name;
    } sb_t;
    sb_t q[$];

    always @(negedge clk) begin
        sb_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            check({e.name, "/due"}, e.due, cyc);
            if (e.is_slot) check({e.name, "/draw_slot"}, int'(bus.draw_slot), e.slot);
            else begin
                check({e.name, "/inside"}, int'(bus.InsideRectangle), e.ins);
                check({e.name, "/offsetX"}, int'(bus.offsetX), e.ox);
                check({e.name, "/offsetY"}, int'(bus.offsetY), e.oy);
            end
        end
    end

    task automatic probe(string name, int px, int py, int ins, int ox, int oy, int slot);
        bus.pixelX = 11'(px);
        bus.pixelY = 11'(py);
        q.push_back('{cyc + 1, 1'b0, ins, ox, oy, slot, name});
        q.push_back('{cyc + 2, 1'b1, ins, ox, oy, slot, name});
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drain", q.size(), 0);
        q.delete();
    endtask

    task automatic frames(int n);
        for (int i = 0; i < n; i++) begin
            bus.startOfFrame = 1'b1;
            @(negedge clk);
            bus.startOfFrame = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic status(string name, int mask, int cnt);
        check({name, "/mask"}, int'(bus.active_mask), mask);
        check({name, "/count"}, int'(bus.enemy_count), cnt);
    endtask

    // Point the scan at a slot, wait for its tag on draw_slot, then pulse hit for one clk.
    task automatic hit_at(int px, int py, int slot);
        bus.pixelX = 11'(px);
        bus.pixelY = 11'(py);
        @(negedge clk);
        @(negedge clk);
        check("hit_tag", int'(bus.draw_slot), slot);
        bus.hit = 1'b1;
        @(negedge clk);
        bus.hit = 1'b0;
    endtask

    typedef struct {int phase, px, py, ins, ox, oy, slot;} vec_t;
    vec_t vt [18];

    task automatic run_phase(int p);
        for (int i = 0; i < 18; i++)
            if (vt[i].phase == p)
                probe($sformatf("vec%0d_%0d", p, i), vt[i].px, vt[i].py,
                      vt[i].ins, vt[i].ox, vt[i].oy, vt[i].slot);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        vt = '{
            // phase 0: slot0 at x=0 (y 64)
            '{0,   0,  64, 1,  0,  0, 0},
            '{0,  31,  95, 1, 31, 31, 0},
            '{0,  32,  64, 0,  0,  0, 0},
            '{0,   5,  63, 0,  0,  0, 0},
            '{0,   5,  96, 0,  0,  0, 0},
            // phase 1: slot0 at x=100
            '{1, 105,  70, 1,  5,  6, 0},
            '{1,  99,  70, 0,  0,  0, 0},
            '{1, 131,  95, 1, 31, 31, 0},
            '{1, 132,  70, 0,  0,  0, 0},
            // phase 2: slot0 x=120, slot1 x=608 (y 80)
            '{2, 610,  85, 1,  2,  5, 1},
            '{2, 639, 111, 1, 31, 31, 1},
            '{2, 640,  85, 0,  0,  0, 0},
            '{2, 125,  70, 1,  5,  6, 0},
            // phase 3: slot0 x=420, slot1 x=428, slot2 x=60 (y 96)
            '{3, 430,  85, 1, 10, 21, 0},
            '{3, 455, 100, 1, 27, 20, 1},
            '{3, 425,  85, 1,  5, 21, 0},
            '{3, 427, 100, 0,  0,  0, 0},
            '{3,  70, 110, 1, 10, 14, 2}
        };

        resetN = 1'b1;
        bus.pixelX = '0; bus.pixelY = '0;
        bus.startOfFrame = 1'b0; bus.lvl_index = 1'b0; bus.hit = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst/inside", int'(bus.InsideRectangle), 0);
        check("rst/draw_slot", int'(bus.draw_slot), 0);
        status("rst", 0, 0);
        resetN = 1'b0;
        bus.lvl_index = 1'b1;

        frames(119);  status("f119", 0, 0);
        frames(1);    status("f120_spawn0", 1, 1);
        run_phase(0);
        frames(100);  status("f220", 1, 1);
        run_phase(1);
        frames(20);   status("f240_spawn1", 3, 2);
        run_phase(2);

        hit_at(610, 85, 1);
        for (int f = 0; f < 16; f++) begin
            int c;
            c = 16 - f;
            if (BLINK && c[1]) probe("dying_vis", 610, 85, 1, 2, 5, 1);
            else               probe("dying_hid", 610, 85, 0, 0, 0, 0);
            frames(1);
            if (f == 14) status("dying_f15", 3, 2);
        end
        drain();
        status("dying_done", 1, 1);

        frames(284);  status("f540", 7, 3);
        run_phase(3);

        // Reset in the middle of a frame while an overlapping pixel is being drawn.
        bus.pixelX = 11'd430; bus.pixelY = 11'd85;
        @(negedge clk); @(negedge clk);
        check("pre_rst/inside", int'(bus.InsideRectangle), 1);
        resetN = 1'b1;
        @(negedge clk);
        resetN = 1'b0;
        check("mid_rst/inside", int'(bus.InsideRectangle), 0);
        check("mid_rst/offsetX", int'(bus.offsetX), 0);
        check("mid_rst/offsetY", int'(bus.offsetY), 0);
        check("mid_rst/draw_slot", int'(bus.draw_slot), 0);
        status("mid_rst", 0, 0);

        frames(119);  status("r_f119", 0, 0);
        frames(1);    status("r_f120", 1, 1);
        run_phase(0);
        frames(359);  status("r_f479", 7, 3);
        frames(1);    status("r_f480_full", 15, 4);
        frames(120);  status("r_f600_hold", 15, 4);
        hit_at(241, 120, 2);
        frames(15);   status("r_f615", 15, 4);
        frames(1);    status("r_f616_freed", 11, 3);
        frames(1);    status("r_f617_respawn", 15, 4);
        frames(111);  status("r_f728", 15, 4);
        probe("edge_608", 639, 64, 1, 31, 0, 0);
        drain();
        frames(1);    status("r_f729_exit", 14, 3);
        probe("after_exit", 639, 64, 0, 0, 0, 0);
        drain();

        bus.lvl_index = 1'b0;
        frames(100);  status("lvl0_f829", 14, 3);
        bus.lvl_index = 1'b1;
        frames(119);  status("lvl1_f948", 12, 2);
        frames(1);    status("lvl1_f949_spawn", 13, 3);

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
